// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants and types for the instruction fetch unit:
//               NOP encoding, SYSTEM opcode, fetch FSM state encoding and the
//               default reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    // addi x0, x0, 0 -- canonical RISC-V NOP used to fill bubbles
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [6:0]  OPCODE_SYSTEM    = 7'b1110011;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch FSM state encoding (explicit width, legacy-compatible constants)
    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t ST_RUN  = 1'b0;
    localparam fetch_state_t ST_HALT = 1'b1;

    // Instruction addresses are word aligned; the low two bits are dropped
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register. Flush inserts a NOP bubble and has
//               priority over load; with neither asserted the contents hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out
);

    logic [31:0] r_pc_q;
    logic [31:0] r_instr_q;
    logic        r_valid_q;
    logic [31:0] w_pc_d;
    logic [31:0] w_instr_d;
    logic        w_valid_d;

    // Next-state selection: flush bubble, new fetch, or hold
    always_comb begin
        w_pc_d    = r_pc_q;
        w_instr_d = r_instr_q;
        w_valid_d = r_valid_q;
        if (flush) begin
            w_pc_d    = 32'h0000_0000;
            w_instr_d = NOP_INSTR;
            w_valid_d = 1'b0;
        end else if (load) begin
            w_pc_d    = pc_in;
            w_instr_d = instr_in;
            w_valid_d = 1'b1;
        end
    end

    // Register update with synchronous reset to an empty bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_q    <= 32'h0000_0000;
            r_instr_q <= NOP_INSTR;
            r_valid_q <= 1'b0;
        end else begin
            r_pc_q    <= w_pc_d;
            r_instr_q <= w_instr_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign pc_out    = r_pc_q;
    assign instr_out = r_instr_q;
    assign valid_out = r_valid_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : Single-issue instruction fetch stage. Owns the PC and the
//               RUN/HALT fetch FSM and feeds the IF/ID register. A SYSTEM
//               opcode stops fetching until reset.
//               Optional macro IFETCH_PERF_CNT_EN enables the fetch/flush
//               performance counters; otherwise both outputs read zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        halted,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
);

    localparam logic [31:0] C_RESET_PC_ALIGNED = align_word(RESET_PC);

    fetch_state_t r_state_q;
    fetch_state_t w_state_d;
    logic [31:0]  r_pc_q;
    logic [31:0]  w_pc_d;
    logic         w_load;
    logic         w_flush;
    logic         w_branch_flush;

    // PC/FSM next state: branch beats stall in RUN; HALT freezes the PC and
    // keeps emitting bubbles unless stalled
    always_comb begin
        w_state_d      = r_state_q;
        w_pc_d         = r_pc_q;
        w_load         = 1'b0;
        w_flush        = 1'b0;
        w_branch_flush = 1'b0;
        case (r_state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    w_pc_d         = align_word(branch_target);
                    w_flush        = 1'b1;
                    w_branch_flush = 1'b1;
                end else if (!stall) begin
                    w_pc_d = r_pc_q + 32'd4;
                    w_load = 1'b1;
                    if (imem_rdata[6:0] == OPCODE_SYSTEM) begin
                        w_state_d = ST_HALT;
                    end
                end
            end
            default: begin
                if (!stall) begin
                    w_flush = 1'b1;
                end
            end
        endcase
    end

    // PC and FSM registers; reset overrides every other control
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_q    <= C_RESET_PC_ALIGNED;
            r_state_q <= ST_RUN;
        end else begin
            r_pc_q    <= w_pc_d;
            r_state_q <= w_state_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst       (reset),
        .load      (w_load),
        .flush     (w_flush),
        .pc_in     (r_pc_q),
        .instr_in  (imem_rdata),
        .pc_out    (ifid_pc),
        .instr_out (ifid_instr),
        .valid_out (ifid_valid)
    );

    assign imem_addr = r_pc_q;
    assign halted    = (r_state_q == ST_HALT);

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt_q;
    logic [31:0] r_flush_cnt_q;
    logic [31:0] w_fetch_cnt_d;
    logic [31:0] w_flush_cnt_d;

    // Counters: one per latched fetch, one per branch flush; both wrap.
    // Bubbles inserted while halted are not branch flushes.
    always_comb begin
        w_fetch_cnt_d = r_fetch_cnt_q + {31'd0, w_load};
        w_flush_cnt_d = r_flush_cnt_q + {31'd0, w_branch_flush};
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_cnt_q <= 32'h0000_0000;
            r_flush_cnt_q <= 32'h0000_0000;
        end else begin
            r_fetch_cnt_q <= w_fetch_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

    assign fetch_count = r_fetch_cnt_q;
    assign flush_count = r_flush_cnt_q;
`else
    assign fetch_count = 32'h0000_0000;
    assign flush_count = 32'h0000_0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed, self-checking bench for instr_fetch_unit. Expected
//               values are queued when each step is driven and compared after
//               the following rising edge. Honours IFETCH_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    localparam logic [31:0] C_NOP = 32'h0000_0013;
    localparam logic [31:0] C_SYS = 32'h0000_0073;

    typedef struct {
        int          step;
        logic [31:0] addr;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic        valid;
        logic        halted;
        logic [31:0] fcnt;
        logic [31:0] lcnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        halted;
    logic [31:0] fetch_count;
    logic [31:0] flush_count;

    int          checks;
    int          failures;
    int          step_no;
    logic [31:0] exp_fetch;
    logic [31:0] exp_flush;
    logic        sys_en;
    logic [31:0] sys_addr;
    exp_t        sbq[$];

    instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .ifid_pc       (ifid_pc),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid),
        .halted        (halted),
        .fetch_count   (fetch_count),
        .flush_count   (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: address-dependent ADDI-class words (never SYSTEM)
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:7] ^ 25'h1A5_A5A5, 7'b0010011};
    endfunction

    always_comb begin
        imem_rdata = (sys_en && (imem_addr == sys_addr)) ? C_SYS : mem_word(imem_addr);
    end

    task automatic check(input int stp, input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL step%0d %s observed=%h expected=%h", stp, name, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected outcome, then compare
    task automatic step(input logic rs, input logic st, input logic br, input logic [31:0] tgt,
                        input logic [31:0] e_addr, input logic [31:0] e_ipc, input logic [31:0] e_instr,
                        input logic e_v, input logic e_h, input int fi, input int fl);
        exp_t e;
        reset         = rs;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        if (rs) begin
            exp_fetch = 32'd0;
            exp_flush = 32'd0;
        end else begin
            exp_fetch = exp_fetch + 32'(fi);
            exp_flush = exp_flush + 32'(fl);
        end
        e.step   = step_no;
        e.addr   = e_addr;
        e.ipc    = e_ipc;
        e.instr  = e_instr;
        e.valid  = e_v;
        e.halted = e_h;
`ifdef IFETCH_PERF_CNT_EN
        e.fcnt   = exp_fetch;
        e.lcnt   = exp_flush;
`else
        e.fcnt   = 32'd0;
        e.lcnt   = 32'd0;
`endif
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL step%0d scoreboard observed=empty expected=entry", step_no);
        end else begin
            e = sbq.pop_front();
            check(e.step, "imem_addr",   imem_addr,           e.addr);
            check(e.step, "ifid_pc",     ifid_pc,             e.ipc);
            check(e.step, "ifid_instr",  ifid_instr,          e.instr);
            check(e.step, "ifid_valid",  {31'd0, ifid_valid}, {31'd0, e.valid});
            check(e.step, "halted",      {31'd0, halted},     {31'd0, e.halted});
            check(e.step, "fetch_count", fetch_count,         e.fcnt);
            check(e.step, "flush_count", flush_count,         e.lcnt);
        end
        step_no++;
    endtask

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks        = 0;
        failures      = 0;
        step_no       = 0;
        exp_fetch     = 32'd0;
        exp_flush     = 32'd0;
        sys_en        = 1'b0;
        sys_addr      = 32'h0000_0040;
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        @(posedge clk);
        #1;

        //   rs    st    br    target         addr           ipc            instr                    v     h   fi fl
        // Reset state (reset overrides a branch request)
        step(1'b1, 1'b0, 1'b1, 32'h0000_0500, 32'h0000_0100, 32'h0000_0000, C_NOP,                   1'b0, 1'b0, 0, 0);
        // Free-running fetch from RESET_PC
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0104, 32'h0000_0100, mem_word(32'h0000_0100), 1'b1, 1'b0, 1, 0);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0108, 32'h0000_0104, mem_word(32'h0000_0104), 1'b1, 1'b0, 1, 0);
        // Two stall cycles at PC=108 hold everything
        step(1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0108, 32'h0000_0104, mem_word(32'h0000_0104), 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0108, 32'h0000_0104, mem_word(32'h0000_0104), 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_010C, 32'h0000_0108, mem_word(32'h0000_0108), 1'b1, 1'b0, 1, 0);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0110, 32'h0000_010C, mem_word(32'h0000_010C), 1'b1, 1'b0, 1, 0);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0114, 32'h0000_0110, mem_word(32'h0000_0110), 1'b1, 1'b0, 1, 0);
        // Branch beats stall, target low bits cleared
        step(1'b0, 1'b1, 1'b1, 32'h0000_0203, 32'h0000_0200, 32'h0000_0000, C_NOP,                   1'b0, 1'b0, 0, 1);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0204, 32'h0000_0200, mem_word(32'h0000_0200), 1'b1, 1'b0, 1, 0);
        // PC wrap at the top of the address space
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000, C_NOP,                   1'b0, 1'b0, 0, 1);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0000, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1'b1, 1'b0, 1, 0);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0004, 32'h0000_0000, mem_word(32'h0000_0000), 1'b1, 1'b0, 1, 0);
        // SYSTEM word under a taken branch is discarded
        sys_en = 1'b1;
        step(1'b0, 1'b0, 1'b1, 32'h0000_003C, 32'h0000_003C, 32'h0000_0000, C_NOP,                   1'b0, 1'b0, 0, 1);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0040, 32'h0000_003C, mem_word(32'h0000_003C), 1'b1, 1'b0, 1, 0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'h0000_0080, 32'h0000_0000, C_NOP,                   1'b0, 1'b0, 0, 1);
        // SYSTEM at 0x40 halts fetch
        step(1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040, 32'h0000_0000, C_NOP,                   1'b0, 1'b0, 0, 1);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0044, 32'h0000_0040, C_SYS,                   1'b1, 1'b1, 1, 0);
        // Stalled in HALT: IF/ID holds the SYSTEM instruction
        step(1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0044, 32'h0000_0040, C_SYS,                   1'b1, 1'b1, 0, 0);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0044, 32'h0000_0000, C_NOP,                   1'b0, 1'b1, 0, 0);
        // Branch ignored in HALT
        step(1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'h0000_0044, 32'h0000_0000, C_NOP,                   1'b0, 1'b1, 0, 0);
        // Reset is the only exit, and it also clears counters
        step(1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0100, 32'h0000_0000, C_NOP,                   1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0104, 32'h0000_0100, mem_word(32'h0000_0100), 1'b1, 1'b0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  hold PC and IF/ID register contents.
REQ-005 SHALL have port branch_taken  input  1  redirect fetch to branch_target, flush IF/ID.
REQ-006 SHALL have port branch_target  input  32  redirect address.
REQ-007 SHALL have port imem_addr  output  32  instruction memory address (equals PC register).
REQ-008 SHALL have port imem_rdata  input  32  instruction at imem_addr, combinational read, same cycle.
REQ-009 SHALL have port ifid_pc  output  32  PC of instruction held in IF/ID.
REQ-010 SHALL have port ifid_instr  output  32  instruction word handed to the control/ALU-control decoder.
REQ-011 SHALL have port ifid_valid  output  1  IF/ID holds a real instruction.
REQ-012 SHALL have port halted  output  1  fetch stopped after a SYSTEM opcode.

Function
REQ-013 SHALL hold a 2-state FSM: RUN, HALT.
REQ-014 In RUN, without stall or branch_taken, each edge SHALL latch ifid_instr<=imem_rdata, ifid_pc<=PC, ifid_valid<=1, PC<=PC+4.
REQ-015 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no error flag.
REQ-016 branch_taken SHALL have priority over stall: PC<=branch_target with bits [1:0] forced to 0; ifid_instr<=NOP (32'h0000_0013); ifid_valid<=0; ifid_pc<=0.
REQ-017 stall without branch_taken SHALL hold PC, ifid_pc, ifid_instr, ifid_valid unchanged.
REQ-018 RUN->HALT SHALL occur on an edge in RUN where imem_rdata[6:0]==7'b1110011, stall=0, branch_taken=0; that instruction is latched valid into IF/ID as in REQ-014.
REQ-019 A SYSTEM opcode fetched while branch_taken=1 SHALL be discarded; no HALT.
REQ-020 In HALT, PC SHALL freeze; each edge SHALL load NOP with ifid_valid=0 unless stall=1; branch_taken SHALL be ignored; halted=1.
REQ-021 HALT SHALL exit only through reset.
REQ-022 Latency: imem_addr to ifid_instr SHALL be one cycle.

Reset
REQ-023 On reset edge: PC<=RESET_PC with bits [1:0] forced to 0, state<=RUN, ifid_instr<=NOP, ifid_pc<=0, ifid_valid<=0, halted<=0.
REQ-024 reset SHALL override stall, branch_taken, and HALT in the same cycle.

Configuration
REQ-025 Macro IFETCH_PERF_CNT_EN SHALL gate 32-bit outputs fetch_count and flush_count.
- Defined: fetch_count increments per REQ-014 or REQ-018 latch; flush_count increments per REQ-016 flush; both wrap; both cleared by reset.
- Undefined: both ports exist, tied to 0, no counter flops.

Structure
REQ-026 Shared package cpu_pkg SHALL hold NOP_INSTR, OPCODE_SYSTEM (7'b1110011), the RUN/HALT state typedef, and the default RESET_PC.
REQ-027 The IF/ID register SHALL be a sub-module if_id_reg (ports: load, flush, pc/instr in, pc/instr/valid out); PC logic and FSM stay in the top.

Verification
REQ-028 Reset with RESET_PC=32'h100, then 3 free cycles -> imem_addr 100,104,108,10C; ifid_pc 100,104,108 with valid=1 from the first edge.
REQ-029 stall=1 for 2 cycles at PC=32'h108 -> imem_addr, ifid_pc, and ifid_instr unchanged; resume at 32'h10C.
REQ-030 branch_taken=1 with target 32'h203 while stall=1 -> PC=32'h200, ifid_instr=32'h13, valid=0 next cycle.
REQ-031 PC=32'hFFFF_FFFC free-running -> next imem_addr=32'h0.
REQ-032 Fetch 32'h0000_0073 at PC 32'h40 -> ifid valid with 73, halted=1, imem_addr stays 32'h44; branch_taken ignored; reset restores RUN.
REQ-033 With IFETCH_PERF_CNT_EN, 5 fetches + 1 flush -> fetch_count=5, flush_count=1; without it, both 0.
